// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if
//   Bundles the decode/execute observation signals and the pipeline control
//   outputs of the hazard controller.
//   master : pipeline side; drives the ID/EX observations, receives controls.
//   slave  : hazard controller side.
//   Signals:
//     i_id_valid, i_id_opcode, i_id_rs1_addr, i_id_rs2_addr : instruction in ID
//     i_ex_opcode, i_ex_rd_addr, i_ex_write_enable          : instruction in EX
//     i_branch_taken                                        : EX redirect
//     o_stall, o_flush                                      : pipeline controls
//     or_state, or_stall_cnt                                : registered status
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
) ();
  logic             i_id_valid;
  logic [6:0]       i_id_opcode;
  logic [4:0]       i_id_rs1_addr;
  logic [4:0]       i_id_rs2_addr;
  logic [6:0]       i_ex_opcode;
  logic [4:0]       i_ex_rd_addr;
  logic             i_ex_write_enable;
  logic             i_branch_taken;
  logic             o_stall;
  logic             o_flush;
  logic [1:0]       or_state;
  logic [CNT_W-1:0] or_stall_cnt;

  modport master (
    output i_id_valid, i_id_opcode, i_id_rs1_addr, i_id_rs2_addr,
    output i_ex_opcode, i_ex_rd_addr, i_ex_write_enable, i_branch_taken,
    input  o_stall, o_flush, or_state, or_stall_cnt
  );

  modport slave (
    input  i_id_valid, i_id_opcode, i_id_rs1_addr, i_id_rs2_addr,
    input  i_ex_opcode, i_ex_rd_addr, i_ex_write_enable, i_branch_taken,
    output o_stall, o_flush, or_state, or_stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Pipeline sequencing controller for the RV32I_Zicsr core. Watches the
//   instructions in ID and EX and produces stall/flush controls for the IF/ID
//   and ID/EX registers:
//     - load-use hazard  : one bubble, then the consumer forwards from MEM
//     - taken redirect   : flush for 1+FLUSH_CYCLES cycles
//     - SYSTEM in ID     : hold ID for DRAIN_CYCLES cycles so older work drains
//   Also keeps a saturating count of cycles with stall or flush active.
//   Ports:
//     i_clk : CPU clock
//     i_rst : asynchronous, active-high reset
//     bus   : hazard_ctrl_if slave (observations in, controls/status out)
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,   // 1..15
  parameter int FLUSH_CYCLES = 1,   // 0..3
  parameter int CNT_W        = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  hazard_ctrl_if.slave bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_LDUSE = 2'd1,
    ST_REDIR = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  // Counter preloads; a zero-length flush redirects straight back to RUN.
  localparam logic [3:0] DRAIN_LOAD  = 4'(DRAIN_CYCLES - 1);
  localparam logic [3:0] FLUSH_LOAD  = (FLUSH_CYCLES > 0) ? 4'(FLUSH_CYCLES - 1) : 4'd0;
  localparam state_t     REDIR_NEXT  = (FLUSH_CYCLES > 0) ? ST_REDIR : ST_RUN;

  // rs1 is a real source for everything except U-type and JAL.
  function automatic logic rs1_used(input logic [6:0] op);
    rs1_used = (op != OP_LUI) && (op != OP_AUIPC) && (op != OP_JAL);
  endfunction

  // rs2 is a real source only for R, S and B formats.
  function automatic logic rs2_used(input logic [6:0] op);
    rs2_used = (op == OP_REG) || (op == OP_STORE) || (op == OP_BRANCH);
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [3:0]       cnt_r;
  logic [3:0]       cnt_nxt_s;
  logic             sticky_r;
  logic             sticky_nxt_s;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             stall_s;
  logic             flush_s;
  logic             ld_hit_s;
  logic             sys_s;
  logic             rs1_hit_s;
  logic             rs2_hit_s;

  // Hazard detection against the load currently in EX.
  always_comb begin
    rs1_hit_s = rs1_used(bus.i_id_opcode) && (bus.i_id_rs1_addr == bus.i_ex_rd_addr);
    rs2_hit_s = rs2_used(bus.i_id_opcode) && (bus.i_id_rs2_addr == bus.i_ex_rd_addr);
    ld_hit_s  = (bus.i_ex_opcode == OP_LOAD) && bus.i_ex_write_enable &&
                (bus.i_ex_rd_addr != 5'd0) && bus.i_id_valid &&
                (rs1_hit_s || rs2_hit_s);
    // The sticky bit masks the SYSTEM instruction on the cycle it finally issues.
    sys_s     = bus.i_id_valid && (bus.i_id_opcode == OP_SYSTEM) && !sticky_r;
  end

  // Next-state and control generation; priority is redirect > load-use > SYSTEM.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    sticky_nxt_s = sticky_r;
    stall_s      = 1'b0;
    flush_s      = 1'b0;
    case (state_r)
      ST_RUN: begin
        sticky_nxt_s = 1'b0;
        if (bus.i_branch_taken) begin
          flush_s     = 1'b1;
          state_nxt_s = REDIR_NEXT;
          cnt_nxt_s   = FLUSH_LOAD;
        end else if (ld_hit_s) begin
          stall_s     = 1'b1;
          state_nxt_s = ST_LDUSE;
        end else if (sys_s) begin
          stall_s = 1'b1;
          // This cycle already counts as one drain cycle.
          if (DRAIN_CYCLES > 1) begin
            state_nxt_s = ST_DRAIN;
            cnt_nxt_s   = DRAIN_LOAD;
          end else begin
            sticky_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_LDUSE: begin
        // Bubble already inserted; the consumer now forwards from MEM.
        sticky_nxt_s = 1'b0;
        if (bus.i_branch_taken) begin
          flush_s     = 1'b1;
          state_nxt_s = REDIR_NEXT;
          cnt_nxt_s   = FLUSH_LOAD;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_REDIR: begin
        // Bubbles carry no valid branch, so a redirect here is ignored.
        flush_s      = 1'b1;
        sticky_nxt_s = 1'b0;
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_RUN;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_DRAIN: begin
        if (bus.i_branch_taken) begin
          // The held SYSTEM instruction is squashed; it must drain again if refetched.
          flush_s      = 1'b1;
          sticky_nxt_s = 1'b0;
          state_nxt_s  = REDIR_NEXT;
          cnt_nxt_s    = FLUSH_LOAD;
        end else begin
          // cnt counts stall cycles left including this one.
          stall_s = 1'b1;
          if (cnt_r <= 4'd1) begin
            state_nxt_s  = ST_RUN;
            cnt_nxt_s    = 4'd0;
            sticky_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r - 4'd1;
          end
        end
      end
      default: begin
        state_nxt_s  = ST_RUN;
        cnt_nxt_s    = 4'd0;
        sticky_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state, drain/flush counter and SYSTEM-issue sticky bit.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r  <= ST_RUN;
      cnt_r    <= 4'd0;
      sticky_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      sticky_r <= sticky_nxt_s;
    end
  end

  // Saturating count of cycles with stall or flush asserted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if ((stall_s || flush_s) && !(&stall_cnt_r)) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  // Controls are forced low while reset is held so the pipeline sees NOPs at once.
  assign bus.o_stall      = stall_s & ~i_rst;
  assign bus.o_flush      = flush_s & ~i_rst;
  assign bus.or_state     = state_r;
  assign bus.or_stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

  localparam logic [6:0] OPI  = 7'b0010011;
  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] ROP  = 7'b0110011;
  localparam logic [6:0] LUI  = 7'b0110111;
  localparam logic [6:0] SYS  = 7'b1110011;

  typedef struct {
    logic       id_valid;
    logic [6:0] id_op;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] ex_op;
    logic [4:0] ex_rd;
    logic       ex_we;
    logic       br;
    logic       e_stall;
    logic       e_flush;
    logic [1:0] e_state;
    logic [31:0] e_cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(32)) bus1 ();
  hazard_ctrl_if #(.CNT_W(2))  bus2 ();

  hazard_ctrl #(.DRAIN_CYCLES(3), .FLUSH_CYCLES(1), .CNT_W(32)) dut1 (
    .i_clk(clk), .i_rst(rst), .bus(bus1)
  );

  hazard_ctrl #(.DRAIN_CYCLES(1), .FLUSH_CYCLES(0), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .bus(bus2)
  );

  function automatic vec_t mk(input logic idv, input logic [6:0] idop,
                              input logic [4:0] r1, input logic [4:0] r2,
                              input logic [6:0] exop, input logic [4:0] exrd,
                              input logic exwe, input logic b,
                              input logic s, input logic f,
                              input logic [1:0] st, input int c);
    vec_t v;
    v.id_valid = idv; v.id_op = idop; v.rs1 = r1; v.rs2 = r2;
    v.ex_op = exop; v.ex_rd = exrd; v.ex_we = exwe; v.br = b;
    v.e_stall = s; v.e_flush = f; v.e_state = st; v.e_cnt = 32'(c);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int which, input vec_t v);
    if (which == 1) begin
      bus1.i_id_valid = v.id_valid;  bus1.i_id_opcode = v.id_op;
      bus1.i_id_rs1_addr = v.rs1;    bus1.i_id_rs2_addr = v.rs2;
      bus1.i_ex_opcode = v.ex_op;    bus1.i_ex_rd_addr = v.ex_rd;
      bus1.i_ex_write_enable = v.ex_we; bus1.i_branch_taken = v.br;
    end else begin
      bus2.i_id_valid = v.id_valid;  bus2.i_id_opcode = v.id_op;
      bus2.i_id_rs1_addr = v.rs1;    bus2.i_id_rs2_addr = v.rs2;
      bus2.i_ex_opcode = v.ex_op;    bus2.i_ex_rd_addr = v.ex_rd;
      bus2.i_ex_write_enable = v.ex_we; bus2.i_branch_taken = v.br;
    end
  endtask

  task automatic check_out(input int which, input string tag, input logic s,
                           input logic f, input logic [1:0] st, input logic [31:0] c);
    if (which == 1) begin
      check({tag, " stall"}, {31'd0, bus1.o_stall}, {31'd0, s});
      check({tag, " flush"}, {31'd0, bus1.o_flush}, {31'd0, f});
      check({tag, " state"}, {30'd0, bus1.or_state}, {30'd0, st});
      check({tag, " cnt"},   bus1.or_stall_cnt, c);
    end else begin
      check({tag, " stall"}, {31'd0, bus2.o_stall}, {31'd0, s});
      check({tag, " flush"}, {31'd0, bus2.o_flush}, {31'd0, f});
      check({tag, " state"}, {30'd0, bus2.or_state}, {30'd0, st});
      check({tag, " cnt"},   {30'd0, bus2.or_stall_cnt}, c);
    end
  endtask

  // Drive at posedge+1, sample at the following negedge, then advance one edge.
  task automatic run_vec(input int which, input vec_t v, input int idx);
    drive(which, v);
    @(negedge clk);
    check_out(which, $sformatf("dut%0d v%0d", which, idx), v.e_stall, v.e_flush, v.e_state, v.e_cnt);
    @(posedge clk);
    #1;
  endtask

  vec_t q1[$];
  vec_t q2[$];
  vec_t idle;
  vec_t csr;

  initial begin
    idle = mk(1'b0, OPI, 5'd0, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0);
    csr  = mk(1'b1, SYS, 5'd1, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 0);

    // DRAIN_CYCLES=3, FLUSH_CYCLES=1
    //          idv   idop r1     r2     exop exrd  we    br    stall flush st   cnt
    q1.push_back(mk(1'b0, OPI, 5'd0, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0));  // 0 idle
    q1.push_back(mk(1'b1, ROP, 5'd5, 5'd7, LW,  5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 0));  // 1 rs1 load-use
    q1.push_back(mk(1'b1, ROP, 5'd5, 5'd7, OPI, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 1));  // 2 LDUSE
    q1.push_back(mk(1'b0, OPI, 5'd0, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1));  // 3
    q1.push_back(mk(1'b1, ROP, 5'd7, 5'd5, LW,  5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1));  // 4 rs2 load-use
    q1.push_back(mk(1'b1, ROP, 5'd7, 5'd5, OPI, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2));  // 5
    q1.push_back(mk(1'b1, ROP, 5'd0, 5'd0, LW,  5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2));  // 6 x0
    q1.push_back(mk(1'b1, LUI, 5'd5, 5'd5, LW,  5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2));  // 7 LUI
    q1.push_back(mk(1'b1, ROP, 5'd5, 5'd7, LW,  5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2));  // 8 no wr_en
    q1.push_back(mk(1'b0, ROP, 5'd5, 5'd7, LW,  5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2));  // 9 ID invalid
    q1.push_back(mk(1'b1, OPI, 5'd1, 5'd5, LW,  5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2));  // 10 rs2 unused
    q1.push_back(mk(1'b1, ROP, 5'd5, 5'd7, LW,  5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 2'd0, 2));  // 11 branch beats ld
    q1.push_back(mk(1'b1, ROP, 5'd5, 5'd7, LW,  5'd5, 1'b1, 1'b1, 1'b0, 1'b1, 2'd2, 3));  // 12 REDIR
    q1.push_back(mk(1'b0, OPI, 5'd0, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4));  // 13
    q1.push_back(mk(1'b1, SYS, 5'd1, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 4));  // 14 CSRRW
    q1.push_back(mk(1'b1, SYS, 5'd1, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 5));  // 15 DRAIN
    q1.push_back(mk(1'b1, SYS, 5'd1, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 6));  // 16 DRAIN
    q1.push_back(mk(1'b1, SYS, 5'd1, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 7));  // 17 issues
    q1.push_back(mk(1'b0, OPI, 5'd0, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 7));  // 18
    q1.push_back(mk(1'b1, SYS, 5'd1, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 7));  // 19 CSR
    q1.push_back(mk(1'b1, SYS, 5'd1, 5'd0, OPI, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd3, 8));  // 20 br in DRAIN
    q1.push_back(mk(1'b0, OPI, 5'd0, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 9));  // 21 REDIR
    q1.push_back(mk(1'b1, SYS, 5'd1, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 10)); // 22 refetch stalls
    q1.push_back(mk(1'b1, SYS, 5'd1, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 11)); // 23
    q1.push_back(mk(1'b1, SYS, 5'd1, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 12)); // 24
    q1.push_back(mk(1'b1, SYS, 5'd1, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 13)); // 25 issues
    q1.push_back(mk(1'b0, OPI, 5'd0, 5'd0, OPI, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 13)); // 26 branch
    q1.push_back(mk(1'b0, OPI, 5'd0, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 14)); // 27 REDIR
    q1.push_back(mk(1'b0, OPI, 5'd0, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 15)); // 28
    q1.push_back(mk(1'b1, ROP, 5'd5, 5'd7, LW,  5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 15)); // 29 load-use
    q1.push_back(mk(1'b1, ROP, 5'd5, 5'd7, OPI, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 16)); // 30 br in LDUSE
    q1.push_back(mk(1'b0, OPI, 5'd0, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 17)); // 31 REDIR
    q1.push_back(mk(1'b0, OPI, 5'd0, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 18)); // 32

    // DRAIN_CYCLES=1, FLUSH_CYCLES=0, CNT_W=2 (saturates at 3)
    q2.push_back(mk(1'b0, OPI, 5'd0, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 0));  // 0
    q2.push_back(mk(1'b0, OPI, 5'd0, 5'd0, OPI, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 0));  // 1 1-cycle flush
    q2.push_back(mk(1'b1, SYS, 5'd1, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1));  // 2 1-cycle drain
    q2.push_back(mk(1'b1, SYS, 5'd1, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2));  // 3 issues
    q2.push_back(mk(1'b0, OPI, 5'd0, 5'd0, OPI, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2));  // 4 from 2
    q2.push_back(mk(1'b0, OPI, 5'd0, 5'd0, OPI, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 3));  // 5
    q2.push_back(mk(1'b1, ROP, 5'd5, 5'd7, LW,  5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 3));  // 6 saturated
    q2.push_back(mk(1'b1, ROP, 5'd5, 5'd7, OPI, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 2'd1, 3));  // 7 br in LDUSE
    q2.push_back(mk(1'b0, OPI, 5'd0, 5'd0, OPI, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3));  // 8

    rst = 1'b1;
    drive(1, idle);
    drive(2, idle);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_out(1, "reset1", 1'b0, 1'b0, 2'd0, 32'd0);
    check_out(2, "reset2", 1'b0, 1'b0, 2'd0, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < q1.size(); i++) run_vec(1, q1[i], i);

    // Asynchronous reset while held in DRAIN.
    drive(1, csr);
    @(negedge clk);
    check_out(1, "drain entry", 1'b1, 1'b0, 2'd0, 32'd18);
    @(posedge clk);
    #1;
    check({"in drain", " state"}, {30'd0, bus1.or_state}, 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check_out(1, "async rst", 1'b0, 1'b0, 2'd0, 32'd0);
    drive(1, idle);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_out(1, "after rst", 1'b0, 1'b0, 2'd0, 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < q2.size(); i++) run_vec(2, q2[i], i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
